// File: rtl/aes_mixcol_if.sv
// Handshake bundle between the AES round datapath and the MixColumns engine.
// The master drives blocks in and consumes results; the slave is the engine.
interface aes_mixcol_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic [1:0]   in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;
    logic         busy;

    modport master (
        output in_valid, in_block, in_mode, out_ready,
        input  in_ready, out_valid, out_block, busy
    );

    modport slave (
        input  in_valid, in_block, in_mode, out_ready,
        output in_ready, out_valid, out_block, busy
    );
endinterface

// File: rtl/aes_mixcol_engine.sv
// Handshaked MixColumns / InvMixColumns / bypass engine for the AES round loop.
// It transforms COLS_PER_CYCLE columns per clock in place in a working register.
module aes_mixcol_engine #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    aes_mixcol_if.slave bus
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("aes_mixcol_engine: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    state_e       state_r;
    state_e       state_next_s;
    logic [127:0] work_r;
    logic [127:0] work_next_s;
    logic [127:0] out_block_r;
    logic [1:0]   mode_r;
    logic [1:0]   col_cnt_r;
    logic [1:0]   col_idx_s;
    logic         accept_s;
    logic         last_group_s;
    logic         in_ready_s;
    logic         out_valid_s;
    logic         busy_s;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        logic [7:0] r;
        if (b[7]) begin
            r = {b[6:0], 1'b0} ^ 8'h1b;
        end else begin
            r = {b[6:0], 1'b0};
        end
        return r;
    endfunction

    // Inverse coefficients are built from the 2x/4x/8x chain: 0e=8+4+2, 0b=8+2+1, 0d=8+4+1, 09=8+1.
    function automatic logic [31:0] col_xform(input logic [31:0] col, input logic [1:0] mode);
        logic [7:0]  a  [4];
        logic [7:0]  x2 [4];
        logic [7:0]  x4 [4];
        logic [7:0]  x8 [4];
        logic [31:0] res;
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[31-8*r -: 8];
            x2[r] = xtime(a[r]);
            x4[r] = xtime(x2[r]);
            x8[r] = xtime(x4[r]);
        end
        res = col;
        case (mode)
            2'b00: begin
                for (int r = 0; r < 4; r++) begin
                    res[31-8*r -: 8] = x2[r] ^ x2[(r+1)%4] ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
                end
            end
            2'b01: begin
                for (int r = 0; r < 4; r++) begin
                    res[31-8*r -: 8] = (x8[r] ^ x4[r] ^ x2[r])
                                     ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
                                     ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
                                     ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
                end
            end
            default: res = col;
        endcase
        return res;
    endfunction

    // Column group transform; column c lives at bit offset 32*(3-c), i.e. {~c, 5'b0}.
    always_comb begin
        work_next_s = work_r;
        col_idx_s   = 2'b00;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            col_idx_s = col_cnt_r + 2'(g);
            work_next_s[{~col_idx_s, 5'b00000} +: 32] = col_xform(work_r[{~col_idx_s, 5'b00000} +: 32], mode_r);
        end
    end

    assign last_group_s = (col_cnt_r == LAST_COL);
    assign accept_s     = bus.in_valid & in_ready_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_next_s = ST_BUSY;
                else          state_next_s = ST_IDLE;
            end
            ST_BUSY: begin
                if (last_group_s) state_next_s = ST_DONE;
                else              state_next_s = ST_BUSY;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    if (accept_s) state_next_s = ST_BUSY;
                    else          state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output decode from the state register; in_ready never depends on in_valid.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        busy_s      = 1'b0;
        case (state_r)
            ST_IDLE: in_ready_s = 1'b1;
            ST_BUSY: busy_s     = 1'b1;
            ST_DONE: begin
                in_ready_s  = bus.out_ready;
                out_valid_s = 1'b1;
                busy_s      = 1'b1;
            end
            default: in_ready_s = 1'b0;
        endcase
    end

    // Working/mode registers, column counter and the result register loaded on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_r      <= 128'h0;
            mode_r      <= 2'b00;
            col_cnt_r   <= 2'b00;
            out_block_r <= 128'h0;
        end else begin
            if (accept_s) begin
                work_r    <= bus.in_block;
                mode_r    <= bus.in_mode;
                col_cnt_r <= 2'b00;
            end else if (state_r == ST_BUSY) begin
                work_r    <= work_next_s;
                col_cnt_r <= col_cnt_r + STEP;
            end else begin
                col_cnt_r <= col_cnt_r;
            end
            if ((state_r == ST_BUSY) && last_group_s) begin
                out_block_r <= work_next_s;
            end else begin
                out_block_r <= out_block_r;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_block = out_block_r;
    assign bus.busy      = busy_s;

endmodule

// File: tb/tb_aes_mixcol_engine.sv
// Scoreboard bench for aes_mixcol_engine; instance i runs with COLS_PER_CYCLE = 1 << i.
module tb_aes_mixcol_engine;

    logic clk;
    logic rst_n;

    logic         tb_in_valid  [3];
    logic [127:0] tb_in_block  [3];
    logic [1:0]   tb_in_mode   [3];
    logic         tb_out_ready [3];
    logic         obs_in_ready  [3];
    logic         obs_out_valid [3];
    logic [127:0] obs_out_block [3];
    logic         obs_busy      [3];

    logic [127:0] exp_q [$];
    int tests_run;
    int tests_failed;

    localparam logic [127:0] FWD_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] FWD_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] INV_IN  = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
    localparam logic [127:0] INV_OUT = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
    localparam logic [127:0] BYP_IN  = 128'h00112233_44556677_8899aabb_ccddeeff;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        aes_mixcol_if bus ();
        assign bus.in_valid  = tb_in_valid[i];
        assign bus.in_block  = tb_in_block[i];
        assign bus.in_mode   = tb_in_mode[i];
        assign bus.out_ready = tb_out_ready[i];
        assign obs_in_ready[i]  = bus.in_ready;
        assign obs_out_valid[i] = bus.out_valid;
        assign obs_out_block[i] = bus.out_block;
        assign obs_busy[i]      = bus.busy;
        aes_mixcol_engine #(.COLS_PER_CYCLE(1 << i)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] blk, input logic [1:0] mode);
        logic [7:0]   k [4];
        logic [7:0]   a [4];
        logic [7:0]   acc;
        logic [127:0] res;
        if (mode[1]) return blk;
        if (mode == 2'b00) begin
            k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01;
        end else begin
            k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09;
        end
        res = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = blk[127-32*c-8*r -: 8];
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ gmul(k[j], a[(r+j)%4]);
                res[127-32*c-8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    // Called at posedge+1: present a block, let one edge accept it, then scramble the inputs.
    task automatic do_accept(input int sel, input logic [127:0] blk, input logic [1:0] mode,
                             input logic [127:0] exp);
        tb_in_valid[sel] = 1'b1;
        tb_in_block[sel] = blk;
        tb_in_mode[sel]  = mode;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        tb_in_valid[sel] = 1'b0;
        tb_in_block[sel] = ~blk;
        tb_in_mode[sel]  = ~mode;
    endtask

    // Counts edges until out_valid, bounded at 20.
    task automatic wait_valid(input int sel, output int n);
        n = 0;
        while (obs_out_valid[sel] !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic release_out(input int sel);
        tb_out_ready[sel] = 1'b1;
        @(posedge clk); #1;
        tb_out_ready[sel] = 1'b0;
    endtask

    task automatic run_one(input int sel, input logic [127:0] blk, input logic [1:0] mode,
                           input logic [127:0] exp, input string name, output logic [127:0] got);
        int n;
        logic [127:0] e;
        do_accept(sel, blk, mode, exp);
        wait_valid(sel, n);
        tests_run++;
        if (n !== (4 >> sel)) begin
            tests_failed++;
            $display("FAIL %s latency sel=%0d: got %0d cycles, expected %0d", name, sel, n, 4 >> sel);
        end
        got = obs_out_block[sel];
        e = exp_q.pop_front();
        tests_run++;
        if (got !== e) begin
            tests_failed++;
            $display("FAIL %s data sel=%0d mode=%0d: got %h expected %h", name, sel, mode, got, e);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tb_in_valid[i] = 1'b0; tb_in_block[i] = 128'h0; tb_in_mode[i] = 2'b00; tb_out_ready[i] = 1'b0;
        end
        #3;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if ({obs_in_ready[i], obs_out_valid[i], obs_busy[i], obs_out_block[i]} !== {3'b100, 128'h0}) begin
                tests_failed++;
                $display("FAIL reset_state sel=%0d: got rdy=%b vld=%b busy=%b blk=%h expected rdy=1 vld=0 busy=0 blk=0",
                         i, obs_in_ready[i], obs_out_valid[i], obs_busy[i], obs_out_block[i]);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_forward();
        logic [127:0] got;
        run_one(0, FWD_IN, 2'b00, FWD_OUT, "forward", got);
        release_out(0);
        tests_run++;
        if (obs_out_valid[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL forward_release: out_valid got %b expected 0", obs_out_valid[0]);
        end
    endtask

    task automatic test_inverse();
        logic [127:0] got;
        for (int s = 0; s < 3; s++) begin
            run_one(s, INV_IN, 2'b01, INV_OUT, "inverse", got);
            release_out(s);
        end
    endtask

    task automatic test_bypass();
        logic [127:0] got;
        for (int s = 0; s < 3; s++) begin
            run_one(s, BYP_IN, 2'b10, BYP_IN, "bypass10", got);
            release_out(s);
            run_one(s, BYP_IN, 2'b11, BYP_IN, "bypass11", got);
            release_out(s);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] held;
        logic [127:0] e;
        int n;
        run_one(1, FWD_IN, 2'b00, FWD_OUT, "b2b_first", held);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (obs_out_block[1] !== FWD_OUT || obs_out_valid[1] !== 1'b1 || obs_in_ready[1] !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall cycle %0d: got blk=%h vld=%b rdy=%b expected blk=%h vld=1 rdy=0",
                         i, obs_out_block[1], obs_out_valid[1], obs_in_ready[1], FWD_OUT);
            end
        end
        tb_out_ready[1] = 1'b1;
        tb_in_valid[1]  = 1'b1;
        tb_in_block[1]  = INV_IN;
        tb_in_mode[1]   = 2'b01;
        exp_q.push_back(INV_OUT);
        #1;
        tests_run++;
        if (obs_in_ready[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_in_ready: got %b expected 1", obs_in_ready[1]);
        end
        @(posedge clk); #1;
        tb_out_ready[1] = 1'b0;
        tb_in_valid[1]  = 1'b0;
        tb_in_block[1]  = 128'h0;
        tests_run++;
        if (obs_out_valid[1] !== 1'b0 || obs_busy[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_after_handshake: got vld=%b busy=%b expected vld=0 busy=1",
                     obs_out_valid[1], obs_busy[1]);
        end
        wait_valid(1, n);
        tests_run++;
        if (n !== 2) begin
            tests_failed++;
            $display("FAIL b2b_latency: got %0d expected 2", n);
        end
        e = exp_q.pop_front();
        tests_run++;
        if (obs_out_block[1] !== e) begin
            tests_failed++;
            $display("FAIL b2b_second: got %h expected %h", obs_out_block[1], e);
        end
        release_out(1);
    endtask

    task automatic test_reset_midop();
        do_accept(0, FWD_IN, 2'b00, FWD_OUT);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({obs_out_valid[0], obs_busy[0], obs_in_ready[0], obs_out_block[0]} !== {3'b001, 128'h0}) begin
            tests_failed++;
            $display("FAIL midop_reset: got vld=%b busy=%b rdy=%b blk=%h expected vld=0 busy=0 rdy=1 blk=0",
                     obs_out_valid[0], obs_busy[0], obs_in_ready[0], obs_out_block[0]);
        end
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (obs_out_valid[0] !== 1'b0 || obs_in_ready[0] !== 1'b1) begin
                tests_failed++;
                $display("FAIL midop_after_release cycle %0d: got vld=%b rdy=%b expected vld=0 rdy=1",
                         i, obs_out_valid[0], obs_in_ready[0]);
            end
        end
    endtask

    task automatic test_random();
        logic [127:0] blk;
        logic [127:0] got;
        logic [127:0] back;
        logic [1:0]   mode;
        int           sel;
        int           stall;
        for (int i = 0; i < 1000; i++) begin
            sel  = i % 3;
            blk  = {$urandom, $urandom, $urandom, $urandom};
            mode = 2'($urandom_range(0, 3));
            run_one(sel, blk, mode, ref_mix(blk, mode), "random", got);
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                tests_run++;
                if (obs_out_block[sel] !== got || obs_out_valid[sel] !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL random_stall %0d: got blk=%h vld=%b expected blk=%h vld=1",
                             i, obs_out_block[sel], obs_out_valid[sel], got);
                end
            end
            release_out(sel);
            if (mode == 2'b00) begin
                run_one(sel, got, 2'b01, blk, "roundtrip", back);
                release_out(sel);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_forward();
        test_inverse();
        test_bypass();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
